// File: rtl/tone_sched_pkg.sv
// Shared types and constants for the four-source tone scheduler.
package tone_sched_pkg;

  localparam int unsigned CNT_W   = 26;
  localparam int unsigned NUM_SRC = 4;

  localparam logic [11:0] FREQ0_DEF = 12'd440;
  localparam logic [11:0] FREQ1_DEF = 12'd494;
  localparam logic [11:0] FREQ2_DEF = 12'd523;
  localparam logic [11:0] FREQ3_DEF = 12'd587;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  // Lowest set index wins; callers only use the result when the vector is nonzero.
  function automatic logic [1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector against a registered copy of the input; reset reloads the history.
module rise_detect #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] sig_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] sig_q;

  // Loading the history every cycle (including reset) keeps held levels from triggering.
  always_ff @(posedge clk) begin
    sig_q <= sig_i;
  end

  assign rise_o = rst ? '0 : (sig_i & ~sig_q);

endmodule

// File: rtl/tone_scheduler.sv
// Priority tone scheduler: plays one note per trigger, preempts on higher priority, queues lower.
module tone_scheduler
  import tone_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 5000000,
  parameter logic [11:0] FREQ0       = FREQ0_DEF,
  parameter logic [11:0] FREQ1       = FREQ1_DEF,
  parameter logic [11:0] FREQ2       = FREQ2_DEF,
  parameter logic [11:0] FREQ3       = FREQ3_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  output logic [11:0] freq,
  output logic        is_playing,
  output logic [3:0]  grant,
  output logic [3:0]  pending
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pend_q, pend_d;
  logic [3:0]        grant_q, grant_d;
  logic [11:0]       freq_q, freq_d;
  logic [3:0]        rise;
  logic [3:0]        higher;
  logic [3:0]        new_grant;
  logic [1:0]        sel_idx;

  function automatic logic [11:0] freq_of(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return FREQ0;
      2'd1:    return FREQ1;
      2'd2:    return FREQ2;
      default: return FREQ3;
    endcase
  endfunction

  rise_detect #(
    .Width(NUM_SRC)
  ) u_rise (
    .clk   (clk),
    .rst   (rst),
    .sig_i (req),
    .rise_o(rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | rise;
    grant_d   = grant_q;
    freq_d    = freq_q;
    // Bits strictly below the one-hot grant are the higher-priority sources.
    higher    = rise & (grant_q - 4'd1);
    new_grant = grant_q;
    sel_idx   = lowest_idx(pend_q);

    unique case (state_q)
      StIdle: begin
        if (pend_q != '0) begin
          pend_d  = (pend_q | rise) & ~(4'b0001 << sel_idx);
          cnt_d   = HOLD_LOAD;
          freq_d  = freq_of(sel_idx);
          grant_d = 4'b0001 << sel_idx;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (higher != '0) new_grant = 4'b0001 << lowest_idx(higher);
        pend_d = (pend_q | rise) & ~new_grant;
        // Preempt or retrigger wins over expiry; the preempted source is simply dropped.
        if ((rise & new_grant) != '0) begin
          cnt_d   = HOLD_LOAD;
          grant_d = new_grant;
          freq_d  = freq_of(lowest_idx(new_grant));
        end else if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GAP_LOAD;
          grant_d = '0;
          freq_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      freq_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      freq_q  <= freq_d;
    end
  end

  assign freq       = freq_q;
  assign grant      = grant_q;
  assign pending    = pend_q;
  assign is_playing = (state_q == StPlay);

endmodule

// File: tb/tb_tone_scheduler.sv
// Scenario bench for tone_scheduler against a note-level reference model.
module tb_tone_scheduler;

  localparam int HOLD = 10;
  localparam int GAP  = 3;
  localparam logic [11:0] FTAB [4] = '{12'd440, 12'd494, 12'd523, 12'd587};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [11:0] freq;
  logic        is_playing;
  logic [3:0]  grant;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 playing m_src, 2 silent gap; m_left = cycles left in mode.
  int         m_mode = 0;
  int         m_left = 0;
  int         m_src  = 0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_prev = '0;

  tone_scheduler #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .freq      (freq),
    .is_playing(is_playing),
    .grant     (grant),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [20:0] model_out();
    logic [11:0] f;
    logic [3:0]  g;
    f = (m_mode == 1) ? FTAB[m_src] : 12'd0;
    g = (m_mode == 1) ? 4'(1 << m_src) : 4'd0;
    return {f, (m_mode == 1), g, m_pend};
  endfunction

  function automatic logic [20:0] dut_out();
    return {freq, is_playing, grant, pending};
  endfunction

  // Drive one clock of stimulus and advance the model to the post-edge state.
  task automatic tick(input logic [3:0] r, input logic rs);
    logic [3:0] e;
    int j;
    @(negedge clk);
    req = r;
    rst = rs;
    if (rs) begin
      m_mode = 0; m_left = 0; m_pend = '0; m_prev = r;
    end else begin
      e = r & ~m_prev;
      m_prev = r;
      case (m_mode)
        0: begin
          if (m_pend != 0) begin
            m_src = lowest(m_pend);
            m_pend = m_pend | e;
            m_pend[m_src] = 1'b0;
            m_mode = 1;
            m_left = HOLD;
          end else m_pend = m_pend | e;
        end
        1: begin
          j = lowest(e);
          if (j >= 0 && j < m_src) m_src = j;
          m_pend = m_pend | e;
          if (e[m_src]) begin
            m_pend[m_src] = 1'b0;
            m_left = HOLD;
          end else if (m_left == 1) begin
            m_mode = 2; m_left = GAP;
          end else m_left--;
        end
        default: begin
          m_pend = m_pend | e;
          if (m_left == 1) m_mode = 0;
          else m_left--;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] r;
    r = 4'($urandom_range(1, 15));
    tick(r, 1'b1);
    checks++;
    if (dut_out() !== 21'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", dut_out(), 21'h0);
    end
    for (int i = 0; i < 3; i++) tick(r, 1'b0);
    checks++;
    if (pending !== 4'b0000 || is_playing !== 1'b0) begin
      errors++; $display("FAIL reset_held_level: pending %b playing %b want 0000 0", pending,
                         is_playing);
    end
  endtask

  task automatic test_single();
    int note_cycles = 0;
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b0);
    checks++;
    if (pending !== 4'b0001 || is_playing !== 1'b0) begin
      errors++; $display("FAIL single_latch: pending %b playing %b want 0001 0", pending,
                         is_playing);
    end
    for (int i = 0; i < 20; i++) begin
      tick(4'b0001, 1'b0);
      if (freq == 12'd440 && grant == 4'b0001) note_cycles++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL single_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (note_cycles != HOLD) begin
      errors++; $display("FAIL single_length: got %0d want %0d", note_cycles, HOLD);
    end
  endtask

  task automatic test_preempt();
    int saw523 = 0;
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    checks++;
    if (freq !== 12'd523) begin
      errors++; $display("FAIL preempt_start: got %0d want 523", freq);
    end
    for (int i = 0; i < 3; i++) tick(4'b0100, 1'b0);
    tick(4'b0101, 1'b0);
    checks++;
    if (freq !== 12'd440 || grant !== 4'b0001 || pending !== 4'b0000) begin
      errors++; $display("FAIL preempt_switch: got %0d %b %b want 440 0001 0000", freq, grant,
                         pending);
    end
    for (int i = 0; i < 30; i++) begin
      tick(4'b0101, 1'b0);
      if (freq == 12'd523) saw523++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL preempt_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (saw523 != 0) begin
      errors++; $display("FAIL preempt_no_resume: got %0d cycles of 523 want 0", saw523);
    end
  endtask

  task automatic test_queue();
    logic [11:0] starts[$];
    logic [11:0] last;
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0011, 1'b0);
    tick(4'b1011, 1'b0);
    checks++;
    if (pending !== 4'b1010) begin
      errors++; $display("FAIL queue_pending: got %b want 1010", pending);
    end
    last = freq;
    for (int i = 0; i < 60; i++) begin
      tick(4'b1011, 1'b0);
      if (last == 12'd0 && freq != 12'd0) starts.push_back(freq);
      last = freq;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL queue_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (starts.size() != 2 || starts[0] != 12'd494 || starts[1] != 12'd587) begin
      errors++; $display("FAIL queue_order: got %0d notes first %0d want 494 then 587",
                         starts.size(), (starts.size() > 0) ? starts[0] : 12'd0);
    end
  endtask

  task automatic test_retrigger();
    int note_cycles = 0;
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    if (freq == 12'd440) note_cycles++;
    for (int i = 1; i < 30; i++) begin
      tick((i == 7) ? 4'b0000 : 4'b0001, 1'b0);
      if (freq == 12'd440) note_cycles++;
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL retrig_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (note_cycles != 18) begin
      errors++; $display("FAIL retrig_length: got %0d want 18", note_cycles);
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] starts[$];
    int          silences[$];
    int          quiet = 0;
    tick(4'b0000, 1'b1);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    checks++;
    if (freq !== 12'd440 || pending !== 4'b1110) begin
      errors++; $display("FAIL simul_first: got %0d %b want 440 1110", freq, pending);
    end
    for (int i = 0; i < 80; i++) begin
      tick(4'b1111, 1'b0);
      if (freq == 12'd0) quiet++;
      else if (quiet != 0) begin
        starts.push_back(freq); silences.push_back(quiet); quiet = 0;
      end
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL simul_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    checks++;
    if (starts.size() != 3 || starts[0] != 12'd494 || starts[1] != 12'd523 ||
        starts[2] != 12'd587) begin
      errors++; $display("FAIL simul_order: got %0d later notes want 494 523 587", starts.size());
    end
    // Silence between notes is the gap plus the one idle cycle that picks the next source.
    foreach (silences[k]) begin
      checks++;
      if (silences[k] != GAP + 1) begin
        errors++; $display("FAIL simul_gap%0d: got %0d want %0d", k, silences[k], GAP + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int played = 0;
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0101, 1'b0);
    checks++;
    if (pending !== 4'b0100 || freq !== 12'd440) begin
      errors++; $display("FAIL rstmid_setup: got %b %0d want 0100 440", pending, freq);
    end
    tick(4'b0101, 1'b1);
    checks++;
    if (dut_out() !== 21'h0) begin
      errors++; $display("FAIL rstmid_clear: got %h want %h", dut_out(), 21'h0);
    end
    for (int i = 0; i < 40; i++) begin
      tick(4'b0101, 1'b0);
      if (freq != 12'd0) played++;
    end
    checks++;
    if (played != 0) begin
      errors++; $display("FAIL rstmid_silent: got %0d playing cycles want 0", played);
    end
  endtask

  task automatic test_random();
    logic [3:0] r = 4'b0000;
    logic       rs;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = r ^ 4'($urandom_range(1, 15));
      rs = ($urandom_range(0, 249) == 0);
      tick(r, rs);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_queue();
    test_retrigger();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the note duration in clk cycles.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 5000000, giving the silent gap after each note in clk cycles.
REQ-003 The block SHALL have parameters FREQ0..FREQ3, defaults 440, 494, 523, 587, giving the 12-bit tone for each source.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-006 The block SHALL have port req, input, 4 bits: one trigger level per source; index 0 has highest priority.
REQ-007 The block SHALL have port freq, output, 12 bits: tone to the oscillator; 0 means silence.
REQ-008 The block SHALL have port is_playing, output, 1 bit: high only in PLAY.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot active source in PLAY, else 0.
REQ-010 The block SHALL have port pending, output, 4 bits: the queued-request register.

Function
REQ-011 A trigger SHALL be a rising edge of req[i], detected against a registered copy of req; a held-high level SHALL NOT re-trigger.
REQ-012 The state machine SHALL have states IDLE, PLAY and GAP.
REQ-013 The note counter SHALL be 26 bits wide and SHALL count down to 0 with no wrap-around.
REQ-014 In IDLE: edges SHALL set their pending bits; a nonzero pending SHALL select the lowest set index i, clear pending[i], load counter=HOLD_CYCLES-1, set freq=FREQi, set grant[i] and enter PLAY.
REQ-015 Latency: a req edge sampled at clock edge k in IDLE SHALL set pending at k, and freq/is_playing SHALL be valid after edge k+1.
REQ-016 In PLAY, an edge on the granted source SHALL reload counter=HOLD_CYCLES-1 (retrigger) and SHALL NOT set its pending bit.
REQ-017 In PLAY, an edge on a higher-priority source j SHALL preempt on the same edge: freq=FREQj, grant=onehot(j), counter reloaded; the preempted source SHALL be dropped, not queued.
REQ-018 In PLAY, an edge on a lower-priority source SHALL set its pending bit.
REQ-019 When the PLAY counter is 0, the block SHALL enter GAP with freq=0, grant=0, is_playing=0 and counter=GAP_CYCLES-1.
REQ-020 In GAP, edges SHALL set pending bits, and counter==0 SHALL return the block to IDLE.
REQ-021 On simultaneous edges, the lowest index SHALL win and all other edges SHALL follow the state's rules.
REQ-022 Retrigger SHALL take precedence over counter expiry on the same cycle.

Reset
REQ-023 When rst is high at a clk edge, the block SHALL enter IDLE with freq=0, is_playing=0, grant=0, pending=0, counter=0, and the req history register loaded with the current req.
REQ-024 Reset mid-PLAY or mid-GAP SHALL abort immediately, and no queued note SHALL play afterwards.

Structure
REQ-025 The state encoding, FREQ defaults and counter width constant SHALL reside in the shared package tone_sched_pkg.
REQ-026 Edge detection SHALL be a sub-module, rise_detect, 4 bits wide, with clk and rst.

Verification (HOLD_CYCLES=10, GAP_CYCLES=3)
REQ-027 Bench SHALL drive req=0001 at cycle 0 -> freq=440 and grant=0001 from cycle 2 for 10 cycles, then freq=0 for 3 cycles, then IDLE.
REQ-028 Bench SHALL drive req[2] in IDLE, then a req[0] edge 4 cycles into PLAY -> freq switches to 440 on the next edge; 523 does not resume; pending=0.
REQ-029 Bench SHALL drive req[1] in PLAY, then a req[3] edge -> pending=1010; after the note and gap, 494 plays, then 587.
REQ-030 Bench SHALL drop and re-raise req[0] at cycle 8 of the note -> counter reloads and the note lasts 18 cycles total.
REQ-031 Bench SHALL raise req=1111 simultaneously in IDLE -> 440 plays first, pending=1110, then 494, 523, 587 in order, each separated by a 3-cycle gap.
REQ-032 Bench SHALL assert rst mid-PLAY with pending=0100 -> all outputs are 0 next cycle and no further note plays.
